// File: rtl/wb_result_sequencer_pkg.sv
// rtl/wb_result_sequencer_pkg.sv - shared constants, encodings and helpers for the writeback sequencer
//
// Purpose: slot destination classes, result size codes, byte-enable lookup
// and the FSM state type used by wb_result_sequencer.
// Ports: none (package).

package wb_result_sequencer_pkg;

  localparam int WB_NUM_RES = 4;
  localparam int WB_DATA_W  = 64;
  localparam int WB_ADDR_W  = 32;
  localparam int WB_SEG_W   = 16;

  // Destination class of one result slot after priority resolution.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_REG  = 2'd1,
    CLS_SEG  = 2'd2,
    CLS_MEM  = 2'd3
  } wb_class_e;

  // Result size codes as presented on ressize.
  typedef enum logic [1:0] {
    SIZE_8  = 2'b00,
    SIZE_16 = 2'b01,
    SIZE_32 = 2'b10,
    SIZE_64 = 2'b11
  } wb_size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } wb_state_e;

  localparam logic [7:0] BE_8  = 8'h01;
  localparam logic [7:0] BE_16 = 8'h03;
  localparam logic [7:0] BE_32 = 8'h0F;
  localparam logic [7:0] BE_64 = 8'hFF;

  // A slot with several class bits set goes to exactly one port: mem wins,
  // then seg, then reg. A wb slot with no class bit completes silently.
  function automatic wb_class_e slot_class(input logic wb, input logic is_reg,
                                           input logic is_seg, input logic is_mem);
    wb_class_e cls;
    cls = CLS_NONE;
    if (wb) begin
      if (is_mem)      cls = CLS_MEM;
      else if (is_seg) cls = CLS_SEG;
      else if (is_reg) cls = CLS_REG;
    end
    return cls;
  endfunction

  function automatic logic [7:0] size_to_be(input wb_size_e size);
    logic [7:0] be;
    case (size)
      SIZE_8:  be = BE_8;
      SIZE_16: be = BE_16;
      SIZE_32: be = BE_32;
      default: be = BE_64;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/wb_result_sequencer_prio_pick.sv
// rtl/wb_result_sequencer_prio_pick.sv - lowest-index priority picker (module wb_prio_pick)
//
// Purpose: selects the lowest set bit of a pending mask.
// Ports:
//   mask_i    in  N    pending mask
//   onehot_o  out N    one-hot of the selected bit (0 when mask empty)
//   idx_o     out IW   index of the selected bit (0 when mask empty)
//   any_o     out 1    mask non-empty

module wb_prio_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
      end
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/wb_result_sequencer.sv
// rtl/wb_result_sequencer.sv - writeback stage draining one execute bundle through reg/seg/store ports
//
// Purpose: captures a bundle of up to NUM_RES results and drains it through
// one GPR write port, one segment write port and one store port. The reg and
// seg ports retire one slot per cycle; the store port retires one slot per
// accepted st_valid/st_ready handshake. ready_out back-pressures execute.
// Optional feature: define WB_PERF_EN to add perf_bundles / perf_st_stall.
// Ports:
//   clk, rst                       clock, async active-low reset
//   valid_in, flush_in             incoming bundle valid / kill
//   res_wb/is_reg/is_seg/is_mem    per-slot writeback enable and class bits
//   res_data, res_dest, ressize    per-slot data, destination, common size code
//   ready_out                      bundle accepted this cycle if valid_in
//   reg_we/addr/data/be            GPR write port
//   seg_we/addr/data               segment write port
//   st_valid/ready/addr/data/size  store request port
//   busy                           bundle pending
//   perf_bundles, perf_st_stall    (WB_PERF_EN only) wrapping event counters

module wb_result_sequencer
  import wb_result_sequencer_pkg::*;
#(
  parameter int NUM_RES = WB_NUM_RES,
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic                      flush_in,
  input  logic [NUM_RES-1:0]        res_wb,
  input  logic [NUM_RES-1:0]        res_is_reg,
  input  logic [NUM_RES-1:0]        res_is_seg,
  input  logic [NUM_RES-1:0]        res_is_mem,
  input  logic [NUM_RES*DATA_W-1:0] res_data,
  input  logic [NUM_RES*ADDR_W-1:0] res_dest,
  input  logic [1:0]                ressize,
  output logic                      ready_out,
  output logic                      reg_we,
  output logic [ADDR_W-1:0]         reg_addr,
  output logic [DATA_W-1:0]         reg_data,
  output logic [7:0]                reg_be,
  output logic                      seg_we,
  output logic [ADDR_W-1:0]         seg_addr,
  output logic [WB_SEG_W-1:0]       seg_data,
  output logic                      st_valid,
  input  logic                      st_ready,
  output logic [ADDR_W-1:0]         st_addr,
  output logic [DATA_W-1:0]         st_data,
  output logic [1:0]                st_size,
`ifdef WB_PERF_EN
  output logic [31:0]               perf_bundles,
  output logic [31:0]               perf_st_stall,
`endif
  output logic                      busy
);

  localparam int IW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

  wb_state_e                        state_q;
  logic [NUM_RES-1:0]               reg_pend_q, seg_pend_q, mem_pend_q;
  logic [NUM_RES-1:0][DATA_W-1:0]   data_q;
  logic [NUM_RES-1:0][ADDR_W-1:0]   dest_q;
  logic [1:0]                       size_q;

  // Pending masks for the bundle currently on the inputs.
  logic [NUM_RES-1:0] in_reg, in_seg, in_mem;
  logic               in_any;

  always_comb begin
    in_reg = '0;
    in_seg = '0;
    in_mem = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      case (slot_class(res_wb[i], res_is_reg[i], res_is_seg[i], res_is_mem[i]))
        CLS_REG: in_reg[i] = 1'b1;
        CLS_SEG: in_seg[i] = 1'b1;
        CLS_MEM: in_mem[i] = 1'b1;
        default: ;
      endcase
    end
  end

  assign in_any = |{in_reg, in_seg, in_mem};

  // One picker per port; each port advances independently of the others.
  logic [NUM_RES-1:0] reg_oh, seg_oh, mem_oh;
  logic [IW-1:0]      reg_idx, seg_idx, mem_idx;
  logic               reg_any, seg_any, mem_any;

  wb_prio_pick #(.N(NUM_RES), .IW(IW)) u_pick_reg (
    .mask_i   (reg_pend_q),
    .onehot_o (reg_oh),
    .idx_o    (reg_idx),
    .any_o    (reg_any)
  );

  wb_prio_pick #(.N(NUM_RES), .IW(IW)) u_pick_seg (
    .mask_i   (seg_pend_q),
    .onehot_o (seg_oh),
    .idx_o    (seg_idx),
    .any_o    (seg_any)
  );

  wb_prio_pick #(.N(NUM_RES), .IW(IW)) u_pick_mem (
    .mask_i   (mem_pend_q),
    .onehot_o (mem_oh),
    .idx_o    (mem_idx),
    .any_o    (mem_any)
  );

  // What remains after this cycle's writes. The store slot only retires on
  // an accepted handshake, which is why ready_out depends on st_ready.
  logic               st_accept;
  logic [NUM_RES-1:0] reg_left, seg_left, mem_left;
  logic               drain_done;
  logic               capture;

  assign st_accept  = mem_any & st_ready;
  assign reg_left   = reg_pend_q & ~reg_oh;
  assign seg_left   = seg_pend_q & ~seg_oh;
  assign mem_left   = st_accept ? (mem_pend_q & ~mem_oh) : mem_pend_q;
  assign drain_done = ~|{reg_left, seg_left, mem_left};

  // Accepting while the last writes of the previous bundle go out keeps
  // back-to-back bundles free of bubbles.
  assign ready_out  = (state_q == ST_IDLE) | drain_done;
  assign capture    = valid_in & ready_out & ~flush_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      reg_pend_q <= '0;
      seg_pend_q <= '0;
      mem_pend_q <= '0;
      data_q     <= '0;
      dest_q     <= '0;
      size_q     <= 2'b00;
    end else if (capture) begin
      reg_pend_q <= in_reg;
      seg_pend_q <= in_seg;
      mem_pend_q <= in_mem;
      if (in_any) begin
        data_q  <= res_data;
        dest_q  <= res_dest;
        size_q  <= ressize;
        state_q <= ST_DRAIN;
      end else begin
        state_q <= ST_IDLE;
      end
    end else begin
      reg_pend_q <= reg_left;
      seg_pend_q <= seg_left;
      mem_pend_q <= mem_left;
      if (drain_done) state_q <= ST_IDLE;
    end
  end

  // Port outputs come straight from registered masks and bundle storage;
  // address/data are zeroed when the port is idle.
  always_comb begin
    reg_we   = reg_any;
    reg_addr = '0;
    reg_data = '0;
    reg_be   = '0;
    if (reg_any) begin
      reg_addr = dest_q[reg_idx];
      reg_data = data_q[reg_idx];
      reg_be   = size_to_be(wb_size_e'(size_q));
    end
  end

  always_comb begin
    seg_we   = seg_any;
    seg_addr = '0;
    seg_data = '0;
    if (seg_any) begin
      seg_addr = dest_q[seg_idx];
      seg_data = data_q[seg_idx][WB_SEG_W-1:0];
    end
  end

  always_comb begin
    st_valid = mem_any;
    st_addr  = '0;
    st_data  = '0;
    st_size  = 2'b00;
    if (mem_any) begin
      st_addr = dest_q[mem_idx];
      st_data = data_q[mem_idx];
      st_size = size_q;
    end
  end

  assign busy = (state_q == ST_DRAIN);

`ifdef WB_PERF_EN
  logic [31:0] perf_bundles_q, perf_st_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bundles_q  <= '0;
      perf_st_stall_q <= '0;
    end else begin
      if (capture)              perf_bundles_q  <= perf_bundles_q + 32'd1;
      if (st_valid & ~st_ready) perf_st_stall_q <= perf_st_stall_q + 32'd1;
    end
  end

  assign perf_bundles  = perf_bundles_q;
  assign perf_st_stall = perf_st_stall_q;
`endif

endmodule

// File: tb/tb_wb_result_sequencer.sv
// tb/tb_wb_result_sequencer.sv - self-checking bench for wb_result_sequencer

module tb_wb_result_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in, flush_in;
  logic [3:0]   res_wb, res_is_reg, res_is_seg, res_is_mem;
  logic [255:0] res_data;
  logic [127:0] res_dest;
  logic [1:0]   ressize;
  logic         ready_out, reg_we, seg_we, st_valid, st_ready, busy;
  logic [31:0]  reg_addr, seg_addr, st_addr;
  logic [63:0]  reg_data, st_data;
  logic [7:0]   reg_be;
  logic [15:0]  seg_data;
  logic [1:0]   st_size;
`ifdef WB_PERF_EN
  logic [31:0]  perf_bundles, perf_st_stall;
`endif

  always #5 clk = ~clk;

  wb_result_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .flush_in   (flush_in),
    .res_wb     (res_wb),
    .res_is_reg (res_is_reg),
    .res_is_seg (res_is_seg),
    .res_is_mem (res_is_mem),
    .res_data   (res_data),
    .res_dest   (res_dest),
    .ressize    (ressize),
    .ready_out  (ready_out),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .reg_be     (reg_be),
    .seg_we     (seg_we),
    .seg_addr   (seg_addr),
    .seg_data   (seg_data),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
`ifdef WB_PERF_EN
    .perf_bundles  (perf_bundles),
    .perf_st_stall (perf_st_stall),
`endif
    .busy       (busy)
  );

  // Reference model: per-port queues of slot indices still to be written.
  int          q_reg[$];
  int          q_seg[$];
  int          q_mem[$];
  logic [63:0] m_data [4];
  logic [31:0] m_dest [4];
  logic [1:0]  m_size;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A new bundle is taken when nothing would be left after this cycle's writes.
  function automatic bit m_ready();
    return (q_reg.size() <= 1) && (q_seg.size() <= 1) &&
           ((q_mem.size() == 0) || ((q_mem.size() == 1) && st_ready));
  endfunction

  task automatic check_outputs();
    logic [31:0] ea;
    logic [63:0] ed;
    logic [7:0]  eb;
    int          nbytes;
    ea = '0; ed = '0; eb = '0;
    if (q_reg.size() > 0) begin
      nbytes = 1 << m_size;
      ea = m_dest[q_reg[0]];
      ed = m_data[q_reg[0]];
      eb = 8'((1 << nbytes) - 1);
    end
    chk("reg_we", reg_we, q_reg.size() > 0);
    chk("reg_addr", reg_addr, ea);
    chk("reg_data", reg_data, ed);
    chk("reg_be", reg_be, eb);
    ea = '0; ed = '0;
    if (q_seg.size() > 0) begin
      ea = m_dest[q_seg[0]];
      ed = {48'd0, m_data[q_seg[0]][15:0]};
    end
    chk("seg_we", seg_we, q_seg.size() > 0);
    chk("seg_addr", seg_addr, ea);
    chk("seg_data", seg_data, ed);
    ea = '0; ed = '0; eb = '0;
    if (q_mem.size() > 0) begin
      ea = m_dest[q_mem[0]];
      ed = m_data[q_mem[0]];
      eb = {6'd0, m_size};
    end
    chk("st_valid", st_valid, q_mem.size() > 0);
    chk("st_addr", st_addr, ea);
    chk("st_data", st_data, ed);
    chk("st_size", st_size, eb);
    chk("ready_out", ready_out, m_ready());
    chk("busy", busy, (q_reg.size() + q_seg.size() + q_mem.size()) > 0);
  endtask

  task automatic model_edge();
    bit acc;
    acc = valid_in && m_ready() && !flush_in;
    if (q_reg.size() > 0) void'(q_reg.pop_front());
    if (q_seg.size() > 0) void'(q_seg.pop_front());
    if (q_mem.size() > 0 && st_ready) void'(q_mem.pop_front());
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        m_data[i] = res_data[i*64 +: 64];
        m_dest[i] = res_dest[i*32 +: 32];
        if (res_wb[i]) begin
          if (res_is_mem[i])      q_mem.push_back(i);
          else if (res_is_seg[i]) q_seg.push_back(i);
          else if (res_is_reg[i]) q_reg.push_back(i);
        end
      end
      m_size = ressize;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid_in = 0; flush_in = 0; res_wb = 0; res_is_reg = 0; res_is_seg = 0;
    res_is_mem = 0; res_data = '0; res_dest = '0; ressize = 2'b11; st_ready = 1;
  endtask

  // cls: 1 reg, 2 seg, 3 mem
  task automatic set_slot(input int i, input int cls, input logic [63:0] d, input logic [31:0] a);
    res_wb[i] = 1'b1;
    res_is_reg[i] = (cls == 1);
    res_is_seg[i] = (cls == 2);
    res_is_mem[i] = (cls == 3);
    res_data[i*64 +: 64] = d;
    res_dest[i*32 +: 32] = a;
  endtask

  initial begin
    int we_cnt;
    rst = 1'b0;
    set_idle();
    m_size = 0;
    for (int i = 0; i < 4; i++) begin m_data[i] = 0; m_dest[i] = 0; end
    @(negedge clk);
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Mixed bundle: reg,reg,seg,mem with a ready store port.
    valid_in = 1; ressize = 2'b10;
    set_slot(0, 1, 64'h1111, 32'hA0);
    set_slot(1, 1, 64'h2222, 32'hA1);
    set_slot(2, 2, 64'h3333, 32'hA2);
    set_slot(3, 3, 64'h4444, 32'hA3);
    step();
    set_idle();
    #2;
    chk("mix c1 reg_addr", reg_addr, 32'hA0);
    chk("mix c1 seg_addr", seg_addr, 32'hA2);
    chk("mix c1 st_addr", st_addr, 32'hA3);
    chk("mix c1 ready_out", ready_out, 0);
    step();
    #2;
    chk("mix c2 reg_addr", reg_addr, 32'hA1);
    chk("mix c2 seg_we", seg_we, 0);
    chk("mix c2 st_valid", st_valid, 0);
    chk("mix c2 ready_out", ready_out, 1);
    step();

    // Store back-pressure: accepted on the fourth cycle.
    valid_in = 1; ressize = 2'b11;
    set_slot(1, 3, 64'hCAFE_0000_1234_5678, 32'h0000_8000);
    step();
    set_idle();
    for (int k = 0; k < 4; k++) begin
      st_ready = (k == 3);
      #2;
      chk("bp st_valid", st_valid, 1);
      chk("bp st_addr", st_addr, 32'h0000_8000);
      chk("bp st_data", st_data, 64'hCAFE_0000_1234_5678);
      chk("bp ready_out", ready_out, (k == 3));
      step();
    end
    set_idle();
    #2;
    chk("bp done st_valid", st_valid, 0);
    step();

    // 16-bit register result.
    valid_in = 1; ressize = 2'b01;
    set_slot(2, 1, 64'hDEAD_BEEF, 32'h7);
    step();
    set_idle();
    #2;
    chk("sz16 reg_be", reg_be, 8'h03);
    chk("sz16 reg_data", reg_data, 64'hDEAD_BEEF);
    step();

    // Flushed bundle is never captured.
    valid_in = 1; flush_in = 1;
    set_slot(0, 1, 64'h55, 32'h9);
    set_slot(1, 3, 64'h66, 32'hA);
    step();
    set_idle();
    #2;
    chk("flush busy", busy, 0);
    chk("flush reg_we", reg_we, 0);
    chk("flush st_valid", st_valid, 0);
    step();

    // Back-to-back single-reg bundles: one write per cycle.
    we_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      set_idle();
      if (k < 4) begin
        valid_in = 1;
        set_slot(0, 1, 64'(k + 100), 32'(k + 32'h40));
      end
      #2;
      if (k > 0) begin
        we_cnt += int'(reg_we);
        chk("b2b reg_addr", reg_addr, 32'(k - 1 + 32'h40));
      end
      step();
    end
    chk("b2b reg_we count", we_cnt, 4);

    // Reset in the middle of a drain.
    set_idle();
    valid_in = 1;
    for (int i = 0; i < 4; i++) set_slot(i, 1, 64'(i), 32'(i + 32'h50));
    set_slot(3, 3, 64'h99, 32'h53);
    step();
    set_idle();
    step();
    rst = 1'b0;
    q_reg.delete(); q_seg.delete(); q_mem.delete();
    @(negedge clk);
    chk("rst reg_we", reg_we, 0);
    chk("rst st_valid", st_valid, 0);
    chk("rst ready_out", ready_out, 1);
    chk("rst busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      valid_in   = ($urandom_range(0, 9) < 7);
      flush_in   = ($urandom_range(0, 9) == 0);
      res_wb     = 4'($urandom);
      res_is_reg = 4'($urandom);
      res_is_seg = 4'($urandom);
      res_is_mem = 4'($urandom);
      for (int i = 0; i < 8; i++) res_data[i*32 +: 32] = $urandom;
      for (int i = 0; i < 4; i++) res_dest[i*32 +: 32] = $urandom;
      ressize    = 2'($urandom);
      st_ready   = ($urandom_range(0, 9) < 6);
      step();
    end
    set_idle();
    for (int n = 0; n < 10; n++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
